// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: PC, in-order imem requests with credit limit,
// fetch buffer of {pc, inst} presented to IF/ID, redirect with stale-response dropping.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Back-to-back redirects can stack stale responses beyond one buffer's worth.
    localparam int DW = AW + 4;
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_buf_pc   [FIFO_DEPTH];
    logic [31:0]   r_buf_inst [FIFO_DEPTH];
    logic [31:0]   r_tag      [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd, r_tag_wr, r_tag_rd;
    logic [CW-1:0] r_count, r_in_flight;
    logic [DW-1:0] r_drop;

    logic          w_redirect, w_pop, w_hs, w_dropping, w_accept, w_push;
    logic [CW:0]   w_credit;

    assign w_redirect = start_i & redirect_i;
    assign w_pop      = start_i & inst_valid_o & ~stall_i & ~redirect_i;
    assign w_hs       = imem_req_o & imem_gnt_i;
    assign w_dropping = (r_drop != '0);
    assign w_accept   = imem_rvalid_i & ~w_dropping;
    assign w_push     = w_accept & ~w_redirect;

    // Buffered plus in-flight words must never exceed the buffer, so every
    // accepted response is guaranteed a slot.
    assign w_credit   = {1'b0, r_in_flight} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
    assign imem_req_o  = start_i & (w_credit < L_DEPTH);
    assign imem_addr_o = r_pc;

    assign inst_valid_o = (r_count != '0);
    assign inst_o       = inst_valid_o ? r_buf_inst[r_rd] : 32'h0;
    assign pc_o         = inst_valid_o ? r_buf_pc[r_rd]   : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pc        <= RESET_PC;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_tag_wr    <= '0;
            r_tag_rd    <= '0;
            r_in_flight <= '0;
            r_drop      <= '0;
        end else if (w_redirect) begin
            r_pc        <= redirect_pc_i;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_tag_wr    <= '0;
            r_tag_rd    <= '0;
            r_in_flight <= '0;
            r_drop      <= r_drop + DW'(r_in_flight) + DW'(w_hs) - DW'(imem_rvalid_i);
        end else begin
            if (w_hs) begin
                r_pc     <= r_pc + 32'd4;
                r_tag_wr <= r_tag_wr + AW'(1);
            end
            if (w_accept) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            if (imem_rvalid_i && w_dropping) begin
                r_drop <= r_drop - DW'(1);
            end
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count     <= r_count + CW'(w_push) - CW'(w_pop);
            r_in_flight <= r_in_flight + CW'(w_hs) - CW'(w_accept);
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && !w_redirect && w_hs) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (rst_n_i && w_push) begin
            r_buf_pc[r_wr]   <= r_tag[r_tag_rd];
            r_buf_inst[r_wr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed + random bench for if_fetch_unit: in-order variable-latency memory model
// and an expected-stream reference (consumed PCs, next fetch address).
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i, start_i, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] inst_o, pc_o;
    logic        inst_valid_o;

    always #5 clk_i = ~clk_i;

    if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0, last_due = 0, lat = 1;
    int          checks = 0, errors = 0, consumed = 0;
    logic [31:0] exp_pc = RST_PC, exp_fetch = RST_PC;
    logic        last_req, last_valid;
    logic [31:0] last_pc, last_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check/update model, then cross the posedge.
    task automatic step(input logic rst_n, input logic start, input logic stall,
                        input logic redir, input logic [31:0] rpc, input logic gnt);
        int d;
        rst_n_i = rst_n; start_i = start; stall_i = stall;
        redirect_i = redir; redirect_pc_i = rpc; imem_gnt_i = gnt;
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = word_of(mq[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        last_req = imem_req_o; last_valid = inst_valid_o;
        last_pc  = pc_o;       last_addr  = imem_addr_o;
        if (rst_n) begin
            chk("fetch_addr", imem_addr_o, exp_fetch);
            if (!start) chk("req_while_frozen", {31'b0, imem_req_o}, 32'd0);
            if (inst_valid_o) begin
                chk("head_pc", pc_o, exp_pc);
                chk("head_inst", inst_o, word_of(exp_pc));
            end else begin
                chk("nop_inst", inst_o, 32'h0);
                chk("nop_pc", pc_o, 32'h0);
            end
            if (start && inst_valid_o && !stall && !redir) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (imem_rvalid_i) void'(mq.pop_front());
            if (imem_req_o && gnt) begin
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                mq.push_back('{addr: imem_addr_o, due: d});
                last_due = d;
            end
            if (start && redir) begin
                exp_pc    = rpc;
                exp_fetch = rpc;
            end else if (imem_req_o && gnt) begin
                exp_fetch = exp_fetch + 32'd4;
            end
        end else begin
            mq.delete();
            exp_pc = RST_PC; exp_fetch = RST_PC; last_due = 0;
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Runs until a valid head appears (bounded); reports its PC or all-ones on timeout.
    task automatic find_valid(output logic [31:0] pc_found);
        pc_found = 32'hFFFF_FFFF;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (last_valid) begin
                pc_found = last_pc;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] found;
        int          base;
        logic        seen_top, seen_wrap;
        rst_n_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        @(negedge clk_i);

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_req", {31'b0, last_req}, 32'd0);
        chk("rst_valid", {31'b0, last_valid}, 32'd0);
        chk("rst_addr", last_addr, RST_PC);

        // Streaming with 1-cycle memory: first valid two cycles after first request
        lat = 1;
        run(1);
        chk("first_req", {31'b0, last_req}, 32'd1);
        run(1);
        chk("valid_latency_early", {31'b0, last_valid}, 32'd0);
        run(1);
        chk("valid_latency", {31'b0, last_valid}, 32'd1);
        chk("first_pc", last_pc, 32'h0);
        run(1);

        // Stall with head 0x8: buffer fills, requests stop, release drains in order
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("stall_head", last_pc, 32'h8);
        chk("stall_req_off", {31'b0, last_req}, 32'd0);
        base = consumed;
        run(5);
        chk("release_burst", consumed - base, 5);

        // 3-cycle latency redirect with words in flight
        lat = 3;
        run(6);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        run(1);
        chk("redir_bubble", {31'b0, last_valid}, 32'd0);
        find_valid(found);
        chk("redir_resume", found, 32'h100);
        run(4);

        // Redirect in a cycle carrying both handshake and response
        lat = 1;
        run(4);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
        run(1);
        chk("redir2_bubble", {31'b0, last_valid}, 32'd0);
        find_valid(found);
        chk("redir2_resume", found, 32'h200);
        run(3);

        // start_i low with words in flight: buffered, frozen, then resumes
        lat = 2;
        run(3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 32'h4444, 1'b1);
        chk("frozen_head", {31'b0, last_valid}, 32'd1);
        base = consumed;
        run(6);
        chk("thaw_progress", {31'b0, consumed > base}, 32'd1);

        // Reset with responses pending, then redirect to top of address space
        lat = 3;
        run(3);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("rst_mid_valid", {31'b0, last_valid}, 32'd0);
        seen_top = 1'b0; seen_wrap = 1'b0;
        for (int i = 0; i < 30 && !seen_wrap; i++) begin
            run(1);
            if (last_valid && last_pc == 32'hFFFF_FFFC) seen_top = 1'b1;
            if (last_valid && last_pc == 32'h0 && seen_top) seen_wrap = 1'b1;
        end
        chk("pc_wrap", {31'b0, seen_wrap}, 32'd1);

        // Random traffic
        base = consumed;
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(1, 4);
            step(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end
        chk("random_progress", {31'b0, (consumed - base) > 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
